inst_encoder: RTL and testbench

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/riscv_pkg.sv | 87 ++++++++
 rtl/inst_packer.sv | 48 ++++
 rtl/inst_encoder.sv | 154 +++++++++++++++
 tb/tb_inst_encoder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I class and ALU-op codes, opcodes and instruction field positions,
// shared by the instruction decoder and inst_encoder.
package riscv_pkg;

    typedef enum logic [3:0] {
        CLS_R      = 4'd0,
        CLS_IALU   = 4'd1,
        CLS_LOAD   = 4'd2,
        CLS_STORE  = 4'd3,
        CLS_LUI    = 4'd4,
        CLS_AUIPC  = 4'd5,
        CLS_BRANCH = 4'd6,
        CLS_JAL    = 4'd7,
        CLS_JALR   = 4'd8
    } inst_class_e;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_SLL  = 5'd2,
        ALU_SLT  = 5'd3,
        ALU_SLTU = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_OR   = 5'd8,
        ALU_AND  = 5'd9,
        ALU_LUI  = 5'd10
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int F7_LSB  = 25;

    function automatic logic [2:0] alu_funct3(input logic [4:0] op);
        logic [2:0] f3;
        case (op)
            ALU_SLL:          f3 = 3'b001;
            ALU_SLT:          f3 = 3'b010;
            ALU_SLTU:         f3 = 3'b011;
            ALU_XOR:          f3 = 3'b100;
            ALU_SRL, ALU_SRA: f3 = 3'b101;
            ALU_OR:           f3 = 3'b110;
            ALU_AND:          f3 = 3'b111;
            default:          f3 = 3'b000;
        endcase
        return f3;
    endfunction

    function automatic logic alu_is_shift(input logic [4:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

    function automatic logic alu_uses_alt(input logic [4:0] op);
        return (op == ALU_SUB) || (op == ALU_SRA);
    endfunction

    // Every RV32I format is the R layout with its slots refilled by scrambled immediates.
    function automatic logic [31:0] pack_fields(input logic [6:0] f7, input logic [4:0] rs2,
                                                input logic [4:0] rs1, input logic [2:0] f3,
                                                input logic [4:0] rd, input logic [6:0] opc);
        logic [31:0] w;
        w = 32'(opc);
        w[RD_LSB  +: 5] = rd;
        w[F3_LSB  +: 3] = f3;
        w[RS1_LSB +: 5] = rs1;
        w[RS2_LSB +: 5] = rs2;
        w[F7_LSB  +: 7] = f7;
        return w;
    endfunction

endpackage

// File: rtl/inst_packer.sv
// inst_packer: combinational RV32I field packing for one encode request; out-of-range
// fields are truncated here, legality is judged by the caller.
module inst_packer
    import riscv_pkg::*;
(
    input  logic [3:0]  cls,
    input  logic [4:0]  alu_op,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word
);

    logic [2:0]  alu_f3;
    logic [6:0]  alu_f7;
    logic [6:0]  b_hi;
    logic [4:0]  b_lo;
    logic [19:0] j_imm;

    always_comb begin
        alu_f3 = alu_funct3(alu_op);
        alu_f7 = alu_uses_alt(alu_op) ? FUNCT7_ALT : FUNCT7_BASE;
        b_hi   = {imm[12], imm[10:5]};
        b_lo   = {imm[4:1], imm[11]};
        j_imm  = {imm[20], imm[10:1], imm[11], imm[19:12]};
        word   = '0;
        case (cls)
            CLS_R:      word = pack_fields(alu_f7, rs2, rs1, alu_f3, rd, OPC_OP);
            CLS_IALU: begin
                if (alu_is_shift(alu_op))
                    word = pack_fields(alu_f7, imm[4:0], rs1, alu_f3, rd, OPC_OP_IMM);
                else
                    word = pack_fields(imm[11:5], imm[4:0], rs1, alu_f3, rd, OPC_OP_IMM);
            end
            CLS_LOAD:   word = pack_fields(imm[11:5], imm[4:0], rs1, funct3, rd, OPC_LOAD);
            CLS_JALR:   word = pack_fields(imm[11:5], imm[4:0], rs1, 3'b000, rd, OPC_JALR);
            CLS_STORE:  word = pack_fields(imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE);
            CLS_BRANCH: word = pack_fields(b_hi, rs2, rs1, funct3, b_lo, OPC_BRANCH);
            CLS_LUI:    word = pack_fields(imm[31:25], imm[24:20], imm[19:15], imm[14:12], rd, OPC_LUI);
            CLS_AUIPC:  word = pack_fields(imm[31:25], imm[24:20], imm[19:15], imm[14:12], rd, OPC_AUIPC);
            CLS_JAL:    word = pack_fields(j_imm[19:13], j_imm[12:8], j_imm[7:3], j_imm[2:0], rd, OPC_JAL);
            default:    word = '0;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: accepts RV32I encode requests and writes each word to successive
// instruction-memory addresses. Define ENC_ILLEGAL_CHECK_EN to reject illegal requests with err.
//
// state    | meaning
// ST_IDLE  | req_ready high, waiting for a request
// ST_WRITE | encoded word on mem_*, held until mem_ready
module inst_encoder
    import riscv_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_class,
    input  logic [4:0]  req_alu_op,
    input  logic [2:0]  req_funct3,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [31:0] req_imm,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    output logic [15:0] inst_count,
    output logic        wrapped,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {ST_IDLE, ST_WRITE} state_e;

    state_e        state_q, state_d;
    logic          live_q;
    logic [AW-1:0] idx_q;
    logic [15:0]   count_q;
    logic          wrapped_q;
    logic [31:0]   word;
    logic          accept;
    logic          illegal;
    logic          done;

    inst_packer u_packer (
        .cls    (req_class),
        .alu_op (req_alu_op),
        .funct3 (req_funct3),
        .rd     (req_rd),
        .rs1    (req_rs1),
        .rs2    (req_rs2),
        .imm    (req_imm),
        .word   (word)
    );

    // live_q keeps req_ready low until the first edge after reset release.
    assign req_ready  = live_q && (state_q == ST_IDLE);
    assign accept     = req_valid && req_ready;
    assign done       = (state_q == ST_WRITE) && mem_ready;
    assign mem_we     = (state_q == ST_WRITE);
    assign mem_addr   = BASE_ADDR + (32'(idx_q) << 2);
    assign inst_count = count_q;
    assign wrapped    = wrapped_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept && !illegal) state_d = ST_WRITE;
            ST_WRITE: if (mem_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wdata <= '0;
        end else if (accept && !illegal) begin
            mem_wdata <= word;
        end
    end

    // DEPTH is a power of two, so the index wraps back to BASE_ADDR on its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            count_q   <= '0;
            wrapped_q <= 1'b0;
        end else if (done) begin
            idx_q <= idx_q + AW'(1);
            if (count_q != 16'hFFFF)
                count_q <= count_q + 16'd1;
            if (idx_q == {AW{1'b1}})
                wrapped_q <= 1'b1;
        end
    end

`ifdef ENC_ILLEGAL_CHECK_EN
    logic signed [31:0] simm;
    logic               fits_i;
    logic               fits_b;
    logic               fits_j;
    logic               err_q;

    assign simm   = req_imm;
    assign fits_i = (simm >= -32'sd2048) && (simm <= 32'sd2047);
    assign fits_b = (simm >= -32'sd4096) && (simm <= 32'sd4095) && !req_imm[0];
    assign fits_j = (simm >= -32'sd1048576) && (simm <= 32'sd1048575) && !req_imm[0];

    always_comb begin
        illegal = 1'b0;
        case (req_class)
            CLS_R:      illegal = (req_alu_op == ALU_LUI);
            CLS_IALU: begin
                if (alu_is_shift(req_alu_op))
                    illegal = (req_imm[31:5] != '0);
                else
                    illegal = !fits_i || (req_alu_op == ALU_SUB) || (req_alu_op == ALU_LUI);
            end
            CLS_LOAD:   illegal = !fits_i || (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
            CLS_STORE:  illegal = !fits_i || (req_funct3 > 3'b010);
            CLS_BRANCH: illegal = !fits_b || (req_funct3[2:1] == 2'b01);
            CLS_JAL:    illegal = !fits_j;
            CLS_JALR:   illegal = !fits_i;
            CLS_LUI, CLS_AUIPC: illegal = 1'b0;
            default:    illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else
            err_q <= accept && illegal;
    end

    assign err = err_q;
`else
    assign illegal = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed encode requests with a scoreboard of expected writes,
// checked by a negedge monitor independent of the stimulus.
module tb_inst_encoder;
    import riscv_pkg::*;

    // Offsets 0,4,8,C,0 of the wrap sequence are relative to this base.
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_class;
    logic [4:0]  req_alu_op;
    logic [2:0]  req_funct3;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [31:0] req_imm;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [15:0] inst_count;
    logic        wrapped;
    logic        err;

    always #5 clk = ~clk;

    inst_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_class  (req_class),
        .req_alu_op (req_alu_op),
        .req_funct3 (req_funct3),
        .req_rd     (req_rd),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_imm    (req_imm),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .inst_count (inst_count),
        .wrapped    (wrapped),
        .err        (err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        time         t_acc;
    } exp_t;

    exp_t sb_q[$];
    time  err_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   exp_idx = 0;
    int   exp_count = 0;
    bit   exp_wrapped = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor
    bit          in_write = 1'b0;
    logic [31:0] held_addr, held_data;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            err_q.delete();
            in_write = 1'b0;
        end else begin
            if (mem_we) begin
                if (!in_write) begin
                    if (sb_q.size() == 0) begin
                        check("spurious_mem_we", {31'b0, mem_we}, 32'd0);
                    end else begin
                        mon_e = sb_q.pop_front();
                        check("mem_addr", mem_addr, mon_e.addr);
                        check("mem_wdata", mem_wdata, mon_e.data);
                        check("we_latency", 32'($time - mon_e.t_acc), 32'd5);
                    end
                    held_addr = mem_addr;
                    held_data = mem_wdata;
                end else begin
                    check("hold_addr", mem_addr, held_addr);
                    check("hold_wdata", mem_wdata, held_data);
                end
                check("ready_in_write", {31'b0, req_ready}, 32'd0);
                check("count_in_write", {16'b0, inst_count}, 32'(exp_count));
                check("wrapped_in_write", {31'b0, wrapped}, {31'b0, exp_wrapped});
                in_write = !mem_ready;
            end else begin
                in_write = 1'b0;
            end
            if (err_q.size() > 0 && $time == err_q[0] + 5) begin
                check("err_pulse", {31'b0, err}, 32'd1);
                void'(err_q.pop_front());
            end else if (err) begin
                check("err_spurious", {31'b0, err}, 32'd0);
            end
        end
    end

    task automatic send(input logic [3:0] cls, input logic [4:0] op, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic [31:0] word, input int stall,
                        input bit illegal);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) check("ready_timeout", {31'b0, req_ready}, 32'd1);
        req_class  = cls;
        req_alu_op = op;
        req_funct3 = f3;
        req_rd     = rd;
        req_rs1    = rs1;
        req_rs2    = rs2;
        req_imm    = imm;
        req_valid  = 1'b1;
        @(posedge clk);
        if (illegal) begin
            err_q.push_back($time);
        end else begin
            e.addr  = BASE + (32'(exp_idx) << 2);
            e.data  = word;
            e.t_acc = $time;
            sb_q.push_back(e);
        end
        #1;
        req_valid = 1'b0;
        if (illegal) begin
            @(negedge clk);
            check("illegal_no_we", {31'b0, mem_we}, 32'd0);
            check("illegal_stays_idle", {31'b0, req_ready}, 32'd1);
            check("illegal_count", {16'b0, inst_count}, 32'(exp_count));
        end else begin
            mem_ready = (stall == 0);
            repeat (stall) @(posedge clk);
            #1 mem_ready = 1'b1;
            @(posedge clk);
            #1 mem_ready = 1'b0;
            exp_count++;
            if (exp_idx == DEPTH - 1) exp_wrapped = 1'b1;
            exp_idx = (exp_idx + 1) % DEPTH;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_class  = '0;
        req_alu_op = '0;
        req_funct3 = '0;
        req_rd     = '0;
        req_rs1    = '0;
        req_rs2    = '0;
        req_imm    = '0;
        mem_ready  = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 32'd0);
        check("rst_we", {31'b0, mem_we}, 32'd0);
        check("rst_addr", mem_addr, BASE);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_count", {16'b0, inst_count}, 32'd0);
        check("rst_wrapped", {31'b0, wrapped}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);

        rst_n = 1'b1;
        #1 check("ready_before_edge", {31'b0, req_ready}, 32'd0);
        @(posedge clk);
        #1 check("ready_first_edge", {31'b0, req_ready}, 32'd1);

        // cls, op, f3, rd, rs1, rs2, imm, expected word, stall cycles, illegal
        send(CLS_R,      ALU_ADD, 3'd0, 5'd3,  5'd1, 5'd2, 32'd0,          32'h002081B3, 0, 1'b0);
        send(CLS_IALU,   ALU_ADD, 3'd0, 5'd1,  5'd0, 5'd0, 32'hFFFF_FFFF,  32'hFFF00093, 3, 1'b0);
        send(CLS_IALU,   ALU_SRA, 3'd0, 5'd5,  5'd5, 5'd0, 32'd3,          32'h4032D293, 0, 1'b0);
        check("no_wrap_yet", {31'b0, wrapped}, 32'd0);
        send(CLS_LUI,    ALU_ADD, 3'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5000,  32'h12345537, 1, 1'b0);
        check("wrapped_after_4", {31'b0, wrapped}, 32'd1);
        check("addr_back_to_base", mem_addr, BASE);
        send(CLS_JAL,    ALU_ADD, 3'd0, 5'd1,  5'd0, 5'd0, 32'd8,          32'h008000EF, 0, 1'b0);
        check("count_after_5", {16'b0, inst_count}, 32'd5);

        send(CLS_R,      ALU_SUB, 3'd0, 5'd3,  5'd1, 5'd2, 32'd0,          32'h402081B3, 0, 1'b0);
        send(CLS_STORE,  ALU_ADD, 3'd2, 5'd0,  5'd1, 5'd2, 32'd8,          32'h0020A423, 0, 1'b0);
        send(CLS_BRANCH, ALU_ADD, 3'd0, 5'd0,  5'd1, 5'd2, 32'd8,          32'h00208463, 0, 1'b0);
        send(CLS_BRANCH, ALU_ADD, 3'd1, 5'd0,  5'd1, 5'd0, 32'hFFFF_FFFC,  32'hFE009EE3, 2, 1'b0);
        send(CLS_LOAD,   ALU_ADD, 3'd2, 5'd5,  5'd2, 5'd0, 32'hFFFF_FFFC,  32'hFFC12283, 0, 1'b0);
        send(CLS_JALR,   ALU_ADD, 3'd7, 5'd0,  5'd1, 5'd0, 32'd0,          32'h00008067, 0, 1'b0);
        send(CLS_AUIPC,  ALU_ADD, 3'd0, 5'd5,  5'd0, 5'd0, 32'h0000_1000,  32'h00001297, 0, 1'b0);
        send(CLS_IALU,   ALU_SLL, 3'd0, 5'd6,  5'd7, 5'd0, 32'd31,         32'h01F39313, 0, 1'b0);
        check("count_after_13", {16'b0, inst_count}, 32'd13);

`ifdef ENC_ILLEGAL_CHECK_EN
        send(CLS_IALU,   ALU_ADD, 3'd0, 5'd1,  5'd0, 5'd0, 32'd2048,       32'h0,        0, 1'b1);
        send(CLS_BRANCH, ALU_ADD, 3'd0, 5'd0,  5'd1, 5'd2, 32'd7,          32'h0,        0, 1'b1);
        send(CLS_STORE,  ALU_ADD, 3'd3, 5'd0,  5'd1, 5'd2, 32'd0,          32'h0,        0, 1'b1);
        check("count_after_illegal", {16'b0, inst_count}, 32'd13);
`else
        send(CLS_IALU,   ALU_ADD, 3'd0, 5'd1,  5'd0, 5'd0, 32'd2048,       32'h80000093, 0, 1'b0);
        check("count_after_truncated", {16'b0, inst_count}, 32'd14);
`endif

        // Reset while a write is pending: the write is dropped and not counted.
        @(negedge clk);
        req_class  = CLS_R;
        req_alu_op = ALU_ADD;
        req_rd     = 5'd3;
        req_rs1    = 5'd1;
        req_rs2    = 5'd2;
        req_imm    = '0;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("rstw_we", {31'b0, mem_we}, 32'd0);
        check("rstw_addr", mem_addr, BASE);
        check("rstw_count", {16'b0, inst_count}, 32'd0);
        check("rstw_wrapped", {31'b0, wrapped}, 32'd0);
        check("rstw_ready", {31'b0, req_ready}, 32'd0);
        exp_idx     = 0;
        exp_count   = 0;
        exp_wrapped = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(CLS_R,      ALU_ADD, 3'd0, 5'd3,  5'd1, 5'd2, 32'd0,          32'h002081B3, 0, 1'b0);
        check("count_after_rstw", {16'b0, inst_count}, 32'd1);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        check("err_queue_drained", 32'(err_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
